// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FIFO status type and default sizes
package uart_pkg;
    localparam int UART_FIFO_DEPTH_DFLT = 16;
    localparam int UART_DATA_W_DFLT = 8;
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } uart_fifo_status_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port array, sync write, async (FWFT) or registered read
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    parameter int FWFT = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    always_comb rdata_d = re_i ? mem_q[raddr_i] : rdata_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end
    assign rdata_o = (FWFT != 0) ? mem_q[raddr_i] : rdata_q;
endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock UART FIFO with FWFT option, thresholds, flush and sticky errors
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W_DFLT,
    parameter int DEPTH = UART_FIFO_DEPTH_DFLT,
    parameter int FWFT = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [LW-1:0]     level_o,
    input  logic              err_clr_i,
    output logic              overflow_o,
    output logic              underflow_o
);
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam uart_fifo_status_t ST_RST = '{full: 1'b0, empty: 1'b1, almost_full: AF_THRESH == 0,
                                             almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_param_err
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2 and thresholds <= DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic rd_valid_q, rd_valid_d;
    uart_fifo_status_t st_q, st_d;
    logic wr_acc, rd_acc, wr_go, rd_go;
    logic [DATA_W-1:0] mem_rdata;

    // flush masks both the pointer moves and the error events of its cycle
    always_comb begin
        rd_acc = rd_en_i & !st_q.empty;
        wr_acc = wr_en_i & (!st_q.full | rd_acc);
        wr_go = wr_acc & !flush_i;
        rd_go = rd_acc & !flush_i;
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(wr_go);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(rd_go);
        level_d = flush_i ? '0 : level_q + LW'(wr_go) - LW'(rd_go);
        rd_valid_d = rd_go;
        st_d.full = level_d == FULL_L;
        st_d.empty = level_d == '0;
        st_d.almost_full = level_d >= AF_L;
        st_d.almost_empty = level_d <= AE_L;
        st_d.overflow = (wr_en_i & !wr_acc & !flush_i) | (st_q.overflow & !err_clr_i);
        st_d.underflow = (rd_en_i & !rd_acc & !flush_i) | (st_q.underflow & !err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
            rd_valid_q <= 1'b0;
            st_q <= ST_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
            rd_valid_q <= rd_valid_d;
            st_q <= st_d;
        end
    end

    uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(FWFT)) u_mem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (wr_go),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (rd_go),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // FWFT output is forced to zero while empty so it never shows stale or unwritten words
    assign rd_data_o = (FWFT != 0 && st_q.empty) ? '0 : mem_rdata;
    assign rd_valid_o = (FWFT != 0) ? !st_q.empty : rd_valid_q;
    assign full_o = st_q.full;
    assign empty_o = st_q.empty;
    assign almost_full_o = st_q.almost_full;
    assign almost_empty_o = st_q.almost_empty;
    assign level_o = level_q;
    assign overflow_o = st_q.overflow;
    assign underflow_o = st_q.underflow;
endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: directed and random checks of standard and FWFT FIFOs against a queue model
module tb_uart_sync_fifo;
    localparam int DEPTH = 16;
    localparam int AF = DEPTH - 2;
    localparam int AE = 2;

    logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, we = 1'b0, re = 1'b0, ec = 1'b0;
    logic [7:0] wd = '0;
    logic [7:0] rd0, rd1;
    logic [4:0] lvl0, lvl1;
    logic rv0, full0, empty0, af0, ae0, ovf0, udf0;
    logic rv1, full1, empty1, af1, ae1, ovf1, udf1;

    logic [7:0] q[$];
    logic [7:0] s_rd;
    bit s_rv, m_ovf, m_udf;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) u0 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .wr_en_i(we), .wr_data_i(wd),
        .rd_en_i(re), .rd_data_o(rd0), .rd_valid_o(rv0), .full_o(full0), .empty_o(empty0),
        .almost_full_o(af0), .almost_empty_o(ae0), .level_o(lvl0), .err_clr_i(ec),
        .overflow_o(ovf0), .underflow_o(udf0));

    uart_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) u1 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .wr_en_i(we), .wr_data_i(wd),
        .rd_en_i(re), .rd_data_o(rd1), .rd_valid_o(rv1), .full_o(full1), .empty_o(empty1),
        .almost_full_o(af1), .almost_empty_o(ae1), .level_o(lvl1), .err_clr_i(ec),
        .overflow_o(ovf1), .underflow_o(udf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [7:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : 8'h00;
        chk("level", lvl0, n);
        chk("full", full0, n == DEPTH);
        chk("empty", empty0, n == 0);
        chk("almost_full", af0, n >= AF);
        chk("almost_empty", ae0, n <= AE);
        chk("overflow", ovf0, m_ovf);
        chk("underflow", udf0, m_udf);
        chk("std_valid", rv0, s_rv);
        chk("std_data", rd0, s_rd);
        chk("fwft_level", lvl1, n);
        chk("fwft_full", full1, n == DEPTH);
        chk("fwft_ae_af", {af1, ae1}, {n >= AF, n <= AE});
        chk("fwft_flags", {ovf1, udf1}, {m_ovf, m_udf});
        chk("fwft_empty", empty1, n == 0);
        chk("fwft_valid", rv1, n > 0);
        chk("fwft_data", rd1, head);
    endtask

    task automatic model_reset();
        q.delete();
        s_rd = 8'h00;
        s_rv = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
        bit racc, wacc;
        we = w; wd = d; re = r; flush = f; ec = c;
        @(posedge clk);
        racc = !f && r && q.size() > 0;
        wacc = !f && w && (q.size() < DEPTH || racc);
        m_ovf = (!f && w && !wacc) || (m_ovf && !c);
        m_udf = (!f && r && !racc) || (m_udf && !c);
        s_rv = racc;
        if (f) q.delete();
        if (racc) s_rd = q.pop_front();
        if (wacc) q.push_back(d);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0);
        step(1, 8'hBB, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h55, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 0, 0);
        for (int i = 5; i < 45; i++) step(1, 8'(i), 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
        step(1, 8'hEE, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        for (int i = 0; i < 6; i++) step(1, 8'(8'h90 + i), i > 3, 0, 0);
        we = 1'b1; wd = 8'hC3; re = 1'b1;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        we = 1'b0; re = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rstn = 1'b1;
        step(1, 8'h12, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
